seg7_scan_decoder: RTL and testbench

Recovers BCD digits from a time-multiplexed, active-low seven-segment display bus: the anode selects plus the shared segment lines driven by the team's BCD-to-segment encoders and display scanner. It qualifies each digit's dwell, decodes the pattern back to a BCD nibble, and assembles a full multi-digit frame. Completed frames go out over a valid/ready handshake. The block sits beside the display path as a self-check and readback monitor for the processor's output value.

---
 rtl/seg7_scan_decoder_pkg.sv | 27 ++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seg7_scan_decoder.sv | 155 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_decoder_pkg.sv
// Shared seven-segment constants and types for the scan decoder.
// Segment vectors are declared [0:6] so the leftmost literal bit is
// segment a; all patterns are active-low (0 = lit).
package seg7_scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IGNORE = 2'd0,
    ST_COUNT  = 2'd1,
    ST_HELD   = 2'd2
  } dwell_state_e;

  localparam logic [0:6] SEG_D0    = 7'b0000001;
  localparam logic [0:6] SEG_D1    = 7'b1001111;
  localparam logic [0:6] SEG_D2    = 7'b0010010;
  localparam logic [0:6] SEG_D3    = 7'b0000110;
  localparam logic [0:6] SEG_D4    = 7'b1001100;
  localparam logic [0:6] SEG_D5    = 7'b0100100;
  localparam logic [0:6] SEG_D6    = 7'b0100000;
  localparam logic [0:6] SEG_D7    = 7'b0001111;
  localparam logic [0:6] SEG_D8    = 7'b0000000;
  localparam logic [0:6] SEG_D9    = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-segment encoder table.
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [0:6] seg,
  output logic [3:0] nibble,
  output logic       illegal
);

  // Map a segment pattern back to its BCD code; anything unknown is flagged.
  always_comb begin
    nibble  = CODE_ERR;
    illegal = 1'b0;
    case (seg)
      SEG_D0:    nibble = 4'd0;
      SEG_D1:    nibble = 4'd1;
      SEG_D2:    nibble = 4'd2;
      SEG_D3:    nibble = 4'd3;
      SEG_D4:    nibble = 4'd4;
      SEG_D5:    nibble = 4'd5;
      SEG_D6:    nibble = 4'd6;
      SEG_D7:    nibble = 4'd7;
      SEG_D8:    nibble = 4'd8;
      SEG_D9:    nibble = 4'd9;
      SEG_BLANK: nibble = CODE_BLANK;
      default: begin
        nibble  = CODE_ERR;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed seven-segment display: qualifies
// each digit dwell, decodes it, assembles a frame and hands it out over
// valid/ready with a sticky overrun flag.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     an,
  input  logic [0:6]            seg,
  output logic [4*DIGITS-1:0]   digitos,
  output logic [DIGITS-1:0]     erro,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // sample stage (p0) and previous sample (p1)
  logic [DIGITS-1:0] an_p0, an_p1;
  logic [0:6]        seg_p0, seg_p1;

  // Register the display bus twice so the dwell logic compares sample to sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      an_p0  <= '1;
      an_p1  <= '1;
      seg_p0 <= '1;
      seg_p1 <= '1;
    end else begin
      an_p0  <= an;
      an_p1  <= an_p0;
      seg_p0 <= seg;
      seg_p1 <= seg_p0;
    end
  end

  logic [3:0] dec_nibble;
  logic       dec_illegal;

  seg7_pattern_decode u_decode (
    .seg     (seg_p0),
    .nibble  (dec_nibble),
    .illegal (dec_illegal)
  );

  dwell_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_onehot, sample_same, capture;

  // Dwell qualification: count identical one-hot samples, capture once per dwell.
  always_comb begin
    sel_onehot  = $onehot(~an_p0);
    sample_same = (an_p0 == an_p1) && (seg_p0 == seg_p1);
    sel_idx     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_p0[i]) sel_idx = IDX_W'(i);
    end
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!sel_onehot) begin
      state_d = ST_IGNORE;
      cnt_d   = '0;
    end else if (!sample_same || state_q == ST_IGNORE) begin
      // first sample of a new value counts as one
      state_d = ST_COUNT;
      cnt_d   = CNT_W'(1);
    end else if (state_q == ST_COUNT) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) begin
        capture = 1'b1;
        state_d = ST_HELD;
      end
    end
  end

  logic [4*DIGITS-1:0] live_nib_q, live_nib_d;
  logic [DIGITS-1:0]   live_err_q, live_err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] digitos_q, digitos_d;
  logic [DIGITS-1:0]   erro_q, erro_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic                frame_done, accept;

  // Frame assembly and output handshake; a completing frame always wins the output register.
  always_comb begin
    live_nib_d  = live_nib_q;
    live_err_d  = live_err_q;
    seen_d      = seen_q;
    digitos_d   = digitos_q;
    erro_d      = erro_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    accept      = out_valid_q && out_ready;
    if (capture) begin
      live_nib_d[{sel_idx, 2'b00} +: 4] = dec_nibble;
      live_err_d[sel_idx]               = dec_illegal;
      seen_d[sel_idx]                   = 1'b1;
    end
    frame_done = &seen_d;
    if (frame_done) begin
      seen_d      = '0;
      digitos_d   = live_nib_d;
      erro_d      = live_err_d;
      out_valid_d = 1'b1;
      if (accept)           overrun_d = 1'b0;
      else if (out_valid_q) overrun_d = 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // Live digit values are pure data; seen gates their use, so they need no reset.
  always_ff @(posedge clock) begin
    live_nib_q <= live_nib_d;
    live_err_q <= live_err_d;
  end

  // Dwell FSM, frame tracking and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IGNORE;
      cnt_q       <= '0;
      seen_q      <= '0;
      digitos_q   <= '0;
      erro_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      digitos_q   <= digitos_d;
      erro_q      <= erro_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign digitos   = digitos_q;
  assign erro      = erro_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus a
// randomized scan checked against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [DIGITS-1:0]   an = '1;
  logic [0:6]          seg = '1;
  logic                out_ready = 1'b0;
  logic [4*DIGITS-1:0] digitos;
  logic [DIGITS-1:0]   erro;
  logic                out_valid;
  logic                overrun;

  int n_cmp = 0;
  int n_err = 0;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clock     (clock),
    .reset     (reset),
    .an        (an),
    .seg       (seg),
    .digitos   (digitos),
    .erro      (erro),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  logic [0:6] pat_tbl [10];

  function automatic logic [4:0] ref_decode(input logic [0:6] p);
    for (int d = 0; d < 10; d++)
      if (p == pat_tbl[d]) return {1'b0, 4'(d)};
    if (p == 7'b1111111) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  // ---------------- reference model ----------------
  // A digit is captured at the edge where the run of identical one-hot
  // inputs seen so far reaches exactly STABLE edges.
  logic [DIGITS+6:0]   run_val = '1;
  int                  run_len = 0;
  logic [3:0]          m_live [DIGITS];
  logic [DIGITS-1:0]   m_lerr = '0;
  logic [DIGITS-1:0]   m_seen = '0;
  logic [4*DIGITS-1:0] exp_dig = '0;
  logic [DIGITS-1:0]   exp_err = '0;
  logic                exp_valid = 1'b0;
  logic                exp_ovr = 1'b0;

  always @(posedge clock) begin
    logic acc, done;
    logic [4:0] dec;
    int idx;
    if (reset) begin
      run_val   = '1;
      run_len   = 0;
      m_seen    = '0;
      exp_dig   = '0;
      exp_err   = '0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      acc  = exp_valid && out_ready;
      done = 1'b0;
      if (run_len == STABLE && $countones(~run_val[DIGITS+6:7]) == 1) begin
        idx = 0;
        for (int i = 0; i < DIGITS; i++) if (!run_val[7+i]) idx = i;
        dec = ref_decode(run_val[6:0]);
        m_live[idx] = dec[3:0];
        m_lerr[idx] = dec[4];
        m_seen[idx] = 1'b1;
        if (&m_seen) begin
          done   = 1'b1;
          m_seen = '0;
        end
      end
      if (done) begin
        for (int i = 0; i < DIGITS; i++) exp_dig[4*i +: 4] = m_live[i];
        exp_err = m_lerr;
        if (acc) exp_ovr = 1'b0;
        else if (exp_valid) exp_ovr = 1'b1;
        exp_valid = 1'b1;
      end else if (acc) begin
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
      end
      if ({an, seg} == run_val) run_len++;
      else begin
        run_val = {an, seg};
        run_len = 1;
      end
    end
  end

  // Hold one digit select and pattern for n clock edges (called at a negedge).
  task automatic dwell(input int idx, input logic [0:6] p, input int n);
    an      = '1;
    an[idx] = 1'b0;
    seg     = p;
    repeat (n) @(negedge clock);
  endtask

  task automatic accept_once();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    an = DIGITS'($urandom); seg = 7'($urandom); out_ready = 1'($urandom);
    @(negedge clock);
    an = DIGITS'($urandom); seg = 7'($urandom); out_ready = 1'($urandom);
    @(negedge clock);
    n_cmp++;
    if (digitos !== '0 || erro !== '0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset: digitos=%h erro=%b valid=%b ovr=%b, required all zero",
               digitos, erro, out_valid, overrun);
    end
    reset = 1'b0; out_ready = 1'b0; an = '1; seg = '1;
    @(negedge clock);
  endtask

  task automatic test_normal_frame();
    out_ready = 1'b0;
    dwell(0, pat_tbl[1], 8);
    dwell(1, pat_tbl[2], 8);
    dwell(2, pat_tbl[3], 8);
    an = 4'b0111; seg = pat_tbl[4];
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid !== (k >= STABLE + 1) || out_valid !== exp_valid) begin
        n_err++;
        $display("FAIL normal_valid_timing k=%0d: out_valid=%b required %b",
                 k, out_valid, (k >= STABLE + 1));
      end
    end
    n_cmp++;
    if (digitos !== 16'h4321 || erro !== 4'b0000 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL normal_frame: digitos=%h erro=%b ovr=%b required 4321/0000/0",
               digitos, erro, overrun);
    end
    accept_once();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL normal_accept: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_glitch_select();
    dwell(0, pat_tbl[5], 8);
    dwell(1, pat_tbl[6], 8);
    dwell(3, pat_tbl[7], 8);
    dwell(2, pat_tbl[3], STABLE - 1);
    an = 4'b0011; repeat (10) @(negedge clock);
    an = 4'b1111; repeat (10) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || out_valid !== exp_valid) begin
      n_err++;
      $display("FAIL glitch_no_frame: out_valid=%b required 0", out_valid);
    end
    dwell(2, pat_tbl[9], 8);
    n_cmp++;
    if (out_valid !== 1'b1 || digitos !== 16'h7965 || digitos !== exp_dig) begin
      n_err++;
      $display("FAIL glitch_then_frame: valid=%b digitos=%h required 1/7965",
               out_valid, digitos);
    end
    accept_once();
  endtask

  task automatic test_illegal_blank();
    dwell(0, pat_tbl[0], 8);
    dwell(1, 7'b1111110, 8);
    dwell(2, pat_tbl[2], 8);
    dwell(3, 7'b1111111, 8);
    n_cmp++;
    if (digitos[7:4] !== 4'hE || erro[1] !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_digit1: nibble=%h erro1=%b required E/1", digitos[7:4], erro[1]);
    end
    n_cmp++;
    if (digitos[15:12] !== 4'hF || erro[3] !== 1'b0) begin
      n_err++;
      $display("FAIL blank_digit3: nibble=%h erro3=%b required F/0", digitos[15:12], erro[3]);
    end
    n_cmp++;
    if (digitos !== 16'hF2E0 || erro !== 4'b0010 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_frame: digitos=%h erro=%b valid=%b required F2E0/0010/1",
               digitos, erro, out_valid);
    end
    accept_once();
  endtask

  task automatic test_overrun();
    dwell(0, pat_tbl[4], 8);
    dwell(1, pat_tbl[3], 8);
    dwell(2, pat_tbl[2], 8);
    dwell(3, pat_tbl[1], 8);
    n_cmp++;
    if (digitos !== 16'h1234 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_first: digitos=%h valid=%b ovr=%b required 1234/1/0",
               digitos, out_valid, overrun);
    end
    dwell(0, pat_tbl[8], 8);
    dwell(1, pat_tbl[7], 8);
    dwell(2, pat_tbl[6], 8);
    dwell(3, pat_tbl[5], 8);
    n_cmp++;
    if (digitos !== 16'h5678 || out_valid !== 1'b1 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_second: digitos=%h valid=%b ovr=%b required 5678/1/1",
               digitos, out_valid, overrun);
    end
    accept_once();
    n_cmp++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_accept: valid=%b ovr=%b required 0/0", out_valid, overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    dwell(0, pat_tbl[1], 8);
    dwell(1, pat_tbl[2], 8);
    dwell(2, pat_tbl[3], 8);
    an = '1; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    dwell(3, pat_tbl[8], 8);
    n_cmp++;
    if (out_valid !== 1'b0 || out_valid !== exp_valid) begin
      n_err++;
      $display("FAIL reset_mid_frame: out_valid=%b required 0", out_valid);
    end
    dwell(0, pat_tbl[9], 8);
    dwell(1, pat_tbl[0], 8);
    dwell(2, pat_tbl[5], 8);
    n_cmp++;
    if (out_valid !== 1'b1 || digitos !== 16'h8509) begin
      n_err++;
      $display("FAIL reset_refill: valid=%b digitos=%h required 1/8509", out_valid, digitos);
    end
    accept_once();
  endtask

  task automatic test_random_scan();
    int n;
    int r;
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        an = '1;
        an[$urandom_range(0, DIGITS - 1)] = 1'b0;
      end else begin
        an = DIGITS'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 7) seg = pat_tbl[$urandom_range(0, 9)];
      else if (r < 8) seg = 7'b1111111;
      else seg = 7'($urandom);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        out_ready = ($urandom_range(0, 9) < 3);
        @(negedge clock);
        n_cmp++;
        if (digitos !== exp_dig || erro !== exp_err ||
            out_valid !== exp_valid || overrun !== exp_ovr) begin
          n_err++;
          $display("FAIL random t=%0d: dig=%h err=%b v=%b o=%b required dig=%h err=%b v=%b o=%b",
                   t, digitos, erro, out_valid, overrun,
                   exp_dig, exp_err, exp_valid, exp_ovr);
        end
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    pat_tbl[0] = 7'b0000001; pat_tbl[1] = 7'b1001111;
    pat_tbl[2] = 7'b0010010; pat_tbl[3] = 7'b0000110;
    pat_tbl[4] = 7'b1001100; pat_tbl[5] = 7'b0100100;
    pat_tbl[6] = 7'b0100000; pat_tbl[7] = 7'b0001111;
    pat_tbl[8] = 7'b0000000; pat_tbl[9] = 7'b0000100;
    for (int i = 0; i < DIGITS; i++) m_live[i] = 4'h0;
    @(negedge clock);
    test_reset();
    test_normal_frame();
    test_glitch_select();
    test_illegal_blank();
    test_overrun();
    test_reset_mid_frame();
    test_random_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
